load_store_unit: RTL and testbench

- Sits between the execute stage and the word-wide data memory.
- Accepts one load/store request at a time, given as opcode, byte address and store data.
- Performs byte-lane alignment and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Drives a word-addressed memory port with 1-cycle synchronous read latency, and reports completion and alignment/range faults.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-wide synchronous data memory
//
// Purpose: accepts one load/store request at a time. It aligns byte lanes and
// sign/zero extends loads, and merges sub-word stores by read-modify-write.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req/opcode/addr/wdata request interface, sampled only in IDLE
//   busy/done/fault       status; fault is meaningful only while done=1
//   rdata                 extended load result, held until the next good load
//   mem_*                 word-addressed memory port, 1-cycle read latency
module load_store_unit #(
    parameter int ADDR_WORDS = 256,
    parameter int MEM_AW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * ADDR_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    // Holds the store data from acceptance, then the merged word for sb/sh.
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              op_legal;
    logic              op_half;
    logic              op_word;
    logic              req_fault;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       merged;

    // Decode of the incoming opcode, only used at acceptance.
    always_comb begin
        op_legal = 1'b1;
        op_half  = 1'b0;
        op_word  = 1'b0;
        case (opcode)
            OP_LB, OP_LBU, OP_SB: ;
            OP_LH, OP_LHU, OP_SH: op_half = 1'b1;
            OP_LW, OP_SW:         op_word = 1'b1;
            default:              op_legal = 1'b0;
        endcase
        req_fault = !op_legal || (addr >= ADDR_LIMIT)
                    || (op_half && addr[0]) || (op_word && (addr[1:0] != 2'b00));
    end

    // Lane extraction from the returned word, and sub-word merge for stores.
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        merged   = mem_rdata;
        if (op_q == OP_SB) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lane_d  = lane_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = opcode;
                    lane_d  = addr[1:0];
                    waddr_d = addr[MEM_AW+1:2];
                    data_d  = wdata;
                    fault_d = req_fault;
                    if (req_fault) begin
                        state_d = S_DONE;
                    end else if (opcode == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                case (op_q)
                    OP_LB: begin
                        rdata_d = {{24{byte_sel[7]}}, byte_sel};
                        state_d = S_DONE;
                    end
                    OP_LBU: begin
                        rdata_d = {24'h0, byte_sel};
                        state_d = S_DONE;
                    end
                    OP_LH: begin
                        rdata_d = {{16{half_sel[15]}}, half_sel};
                        state_d = S_DONE;
                    end
                    OP_LHU: begin
                        rdata_d = {16'h0, half_sel};
                        state_d = S_DONE;
                    end
                    OP_LW: begin
                        rdata_d = mem_rdata;
                        state_d = S_DONE;
                    end
                    default: begin
                        // Only sb/sh reach CAP besides loads.
                        data_d  = merged;
                        state_d = S_WR;
                    end
                endcase
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 6'h0;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fault     = done && fault_q;
    assign rdata     = rdata_q;
    assign mem_addr  = waddr_q;
    assign mem_read  = (state_q == S_RD);
    assign mem_write = (state_q == S_WR);
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [7:0]  mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rdata = 32'h0;

    load_store_unit #(.ADDR_WORDS(256), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset), .req(req), .opcode(opcode), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous read, write commits at the edge.
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: architectural effect of one request.
    task automatic ref_exec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                            output int f, output int lat, output int rd_cyc,
                            output int wr_cyc, output int widx, output logic [31:0] wword);
        int size;
        bit legal, is_load, sgn;
        logic [31:0] w, smask, val, m;
        int off;
        legal = 1; is_load = 0; sgn = 0; size = 1;
        case (op)
            LB:  begin size = 1; is_load = 1; sgn = 1; end
            LBU: begin size = 1; is_load = 1; end
            LH:  begin size = 2; is_load = 1; sgn = 1; end
            LHU: begin size = 2; is_load = 1; end
            LW:  begin size = 4; is_load = 1; end
            SB:  size = 1;
            SH:  size = 2;
            SW:  size = 4;
            default: legal = 0;
        endcase
        f = (!legal || a >= 32'd1024 || (a % size) != 0) ? 1 : 0;
        rd_cyc = 0; wr_cyc = 0; widx = 0; wword = 32'h0;
        if (f == 1) begin
            lat = 1;
            return;
        end
        widx  = int'(a / 4);
        off   = int'(a % 4);
        smask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        w = ref_mem[widx];
        if (is_load) begin
            lat = 3; rd_cyc = 1;
            val = (w >> (8 * off)) & smask;
            if (sgn && val[8*size-1]) val = val | ~smask;
            ref_rdata = val;
        end else begin
            m = smask << (8 * off);
            wword = (w & ~m) | ((wd & smask) << (8 * off));
            ref_mem[widx] = wword;
            if (size == 4) begin
                lat = 2; wr_cyc = 1;
            end else begin
                lat = 4; rd_cyc = 1; wr_cyc = 3;
            end
        end
    endtask

    // Issue one request from an idle cycle, observe it, compare with the model.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output int d_fault, output int d_lat);
        int e_f, e_lat, e_rd, e_wr, e_idx;
        logic [31:0] e_word;
        int rd_cyc, wr_cyc, nrd, nwr;
        logic [7:0] raddr, waddr;
        logic [31:0] wword;
        ref_exec(op, a, wd, e_f, e_lat, e_rd, e_wr, e_idx, e_word);
        d_fault = -1; d_lat = 0; rd_cyc = 0; wr_cyc = 0; nrd = 0; nwr = 0;
        raddr = 0; waddr = 0; wword = 0;
        req = 1'b1; opcode = op; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; opcode = 6'($urandom); addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 12; c++) begin
            chk("busy_during_access", {31'h0, busy}, 32'h1);
            chk("rd_wr_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
            if (mem_read) begin
                nrd++;
                if (rd_cyc == 0) begin rd_cyc = c; raddr = mem_addr; end
            end
            if (mem_write) begin
                nwr++;
                if (wr_cyc == 0) begin wr_cyc = c; waddr = mem_addr; wword = mem_wdata; end
            end
            if (done) begin
                d_lat = c;
                d_fault = int'(fault);
                chk("done_no_mem_strobe", {30'h0, mem_read, mem_write}, 32'h0);
                break;
            end
            @(posedge clk); #1;
        end
        if (d_lat == 0) chk("done_timeout", 32'h0, 32'h1);
        chk("fault", 32'(d_fault), 32'(e_f));
        chk("latency", 32'(d_lat), 32'(e_lat));
        chk("read_cycle", 32'(rd_cyc), 32'(e_rd));
        chk("read_count", 32'(nrd), (e_rd != 0) ? 32'h1 : 32'h0);
        chk("write_cycle", 32'(wr_cyc), 32'(e_wr));
        chk("write_count", 32'(nwr), (e_wr != 0) ? 32'h1 : 32'h0);
        if (e_rd != 0) chk("read_addr", {24'h0, raddr}, 32'(e_idx));
        if (e_wr != 0) begin
            chk("write_addr", {24'h0, waddr}, 32'(e_idx));
            chk("write_data", wword, e_word);
        end
        chk("rdata", rdata, ref_rdata);
        @(posedge clk); #1;
        chk("idle_after_done", {30'h0, busy, done}, 32'h0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        int          exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int f, l, ndone, nwr, diff;
        logic [5:0] rop;
        logic [31:0] ra;
        logic [5:0] ops[8];
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[3] = 32'h8899AABB;
        ref_mem[3] = 32'h8899AABB;

        vecs.push_back('{LB,    32'h0D,  32'h0,        32'hFFFFFFAA, 0, 3});
        vecs.push_back('{LBU,   32'h0D,  32'h0,        32'h000000AA, 0, 3});
        vecs.push_back('{LH,    32'h0E,  32'h0,        32'hFFFF8899, 0, 3});
        vecs.push_back('{LHU,   32'h0C,  32'h0,        32'h0000AABB, 0, 3});
        vecs.push_back('{LW,    32'h0C,  32'h0,        32'h8899AABB, 0, 3});
        vecs.push_back('{SB,    32'h0C,  32'h12345677, 32'h8899AABB, 0, 4});
        vecs.push_back('{LW,    32'h0C,  32'h0,        32'h8899AA77, 0, 3});
        vecs.push_back('{SW,    32'h0E,  32'h11111111, 32'h8899AA77, 1, 1});
        vecs.push_back('{LH,    32'h0D,  32'h0,        32'h8899AA77, 1, 1});
        vecs.push_back('{LW,    32'h400, 32'h0,        32'h8899AA77, 1, 1});
        vecs.push_back('{6'h00, 32'h0C,  32'h0,        32'h8899AA77, 1, 1});
        vecs.push_back('{SH,    32'h0E,  32'h5555CAFE, 32'h8899AA77, 0, 4});
        vecs.push_back('{LW,    32'h0C,  32'h0,        32'hCAFEAA77, 0, 3});
        vecs.push_back('{LB,    32'h0F,  32'h0,        32'hFFFFFFCA, 0, 3});

        // Reset values, checked while reset is still held.
        #12;
        chk("reset_status", {28'h0, busy, done, fault, mem_read}, 32'h0);
        chk("reset_write", {31'h0, mem_write}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].wd, f, l);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_fault", i), 32'(f), 32'(vecs[i].exp_fault));
            chk($sformatf("vec%0d_latency", i), 32'(l), 32'(vecs[i].exp_lat));
        end

        // Reset during CAP of a load abandons it with no clock edge needed.
        req = 1'b1; opcode = LW; addr = 32'h0C; wdata = 32'h0;
        @(posedge clk); #1; req = 1'b0;
        chk("mid_reset_rd_cycle", {31'h0, mem_read}, 32'h1);
        @(posedge clk); #1;
        chk("mid_reset_in_cap", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_reset_status", {27'h0, busy, done, fault, mem_read, mem_write}, 32'h0);
        chk("mid_reset_rdata", rdata, 32'h0);
        chk("mid_reset_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("mid_reset_mem_wdata", mem_wdata, 32'h0);
        ref_rdata = 32'h0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(SW, 32'h10, 32'hDEADBEEF, f, l);
        chk("post_reset_sw_latency", 32'(l), 32'd2);
        chk("post_reset_sw_mem", ref_mem[4], 32'hDEADBEEF);

        // A second request pulsed during RD is ignored.
        req = 1'b1; opcode = LW; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b1; opcode = SW; addr = 32'h10; wdata = 32'h01020304;
        @(posedge clk); #1;
        req = 1'b0;
        ndone = 0; nwr = 0;
        for (int c = 2; c < 10; c++) begin
            if (done) ndone++;
            if (mem_write) nwr++;
            @(posedge clk); #1;
        end
        chk("busy_req_done_count", 32'(ndone), 32'd1);
        chk("busy_req_no_write", 32'(nwr), 32'd0);
        chk("busy_req_rdata", rdata, 32'hDEADBEEF);
        ref_rdata = 32'hDEADBEEF;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rop = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            ra  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            run_op(rop, ra, $urandom, f, l);
        end

        diff = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
        chk("final_memory_diff_words", 32'(diff), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
